// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a register-array memory, with configurable wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave #(
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                      hclk_i,
  input  logic                      hreset_i,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hmastlock_i,
  input  logic                      hready_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      hreadyout_o,
  output logic                      hresp_o
);

  localparam int NumBytes = AHB_DATA_WIDTH / 8;
  localparam int OffW     = $clog2(NumBytes);
  localparam int IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CntW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned WaitLoad = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;
  logic [AHB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                      accept;
  logic                      align_ok;
  logic                      legal;
  logic [AHB_ADDR_WIDTH-1:0] word_idx;
  state_e                    launch_st;
  logic [NumBytes-1:0]       byte_en;
  logic                      unused_ok;

  assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};
  assign accept    = hsel_i & hready_i & htrans_i[1];
  assign word_idx  = haddr_i >> OffW;

  always_comb begin
    align_ok = 1'b1;
    for (int i = 0; i < OffW; i++) begin
      if ((3'(i) < hsize_i) && haddr_i[i]) align_ok = 1'b0;
    end
  end

  assign legal = (hsize_i <= 3'(OffW)) && align_ok &&
                 (word_idx < AHB_ADDR_WIDTH'(MEM_DEPTH));
  assign launch_st = !legal ? StErr1 : ((WAIT_STATES == 0) ? StData : StWait);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      StIdle, StData, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          state_d = launch_st;
          cnt_d   = CntW'(WaitLoad);
          idx_d   = word_idx[IdxW-1:0];
          off_d   = haddr_i[OffW-1:0];
          size_d  = hsize_i;
          write_d = hwrite_i;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StData;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    hrdata_o    = '0;
    unique case (state_q)
      StWait: hreadyout_o = 1'b0;
      StData: if (!write_q) hrdata_o = mem_q[idx_q];
      StErr1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      StErr2:  hresp_o = 1'b1;
      default: ;
    endcase
  end

  // Little-endian lanes covered by the latched size starting at the latched offset.
  always_comb begin
    for (int b = 0; b < NumBytes; b++) begin
      byte_en[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
    end
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Write commits on the edge that ends the data phase; memory itself is never reset.
  always_ff @(posedge hclk_i) begin
    if (!hreset_i && (state_q == StData) && write_q) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (byte_en[b]) mem_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) behind one pipelined master,
// table-driven transfers checked through a scoreboard plus hand-written corner sequences.
module tb_ahb_sram_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] exp_rd;
    logic        err;
    int          cycles;
    int          id;
  } sb_t;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        sel0 = 1'b0, sel3 = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic        force_lo = 1'b0;
  logic        on3 = 1'b0;
  logic        hready;
  logic [31:0] rd0, rd3;
  logic        ro0, ro3, rs0, rs3;

  vec_t tab[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  assign hready = ro0 & ro3 & ~force_lo;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .hclk_i(clk), .hreset_i(hreset), .hsel_i(sel0), .haddr_i(haddr), .hwdata_i(hwdata),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'h3),
    .htrans_i(htrans), .hmastlock_i(1'b0), .hready_i(hready),
    .hrdata_o(rd0), .hreadyout_o(ro0), .hresp_o(rs0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) dut3 (
    .hclk_i(clk), .hreset_i(hreset), .hsel_i(sel3), .haddr_i(haddr), .hwdata_i(hwdata),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'h3),
    .htrans_i(htrans), .hmastlock_i(1'b0), .hready_i(hready),
    .hrdata_o(rd3), .hreadyout_o(ro3), .hresp_o(rs3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] wd, input logic [31:0] ex, input logic err);
    tab.push_back('{wr, a, s, wd, ex, err});
  endfunction

  // Waits (from a point just after a rising edge) until hready is high at a falling edge,
  // then scores the data phase that completes on the following rising edge.
  task automatic finish_phase(input bit have_prev);
    int          cyc = 1;
    bit          low_ok = 1'b1;
    sb_t         e;
    logic        act_rs;
    logic [31:0] act_rd;
    @(negedge clk);
    while (!hready) begin
      if (cyc > 40) begin
        checks++;
        errors++;
        $display("FAIL timeout: hready stuck low");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
      if (have_prev && ((on3 ? rs3 : rs0) !== sb_q[0].err)) low_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    if (have_prev) begin
      e      = sb_q.pop_front();
      act_rs = on3 ? rs3 : rs0;
      act_rd = on3 ? rd3 : rd0;
      check($sformatf("v%0d hresp", e.id), 32'(act_rs), 32'(e.err));
      check($sformatf("v%0d cycles", e.id), 32'(cyc), 32'(e.cycles));
      check($sformatf("v%0d stall_hresp_ok", e.id), 32'(low_ok), 32'd1);
      if (!e.wr && !e.err) check($sformatf("v%0d hrdata", e.id), act_rd, e.exp_rd);
    end
  endtask

  // Issues every table entry as back-to-back NONSEQ transfers to the selected instance.
  task automatic run_tab();
    bit   have_prev = 1'b0;
    vec_t prev;
    for (int i = 0; i <= tab.size(); i++) begin
      if (i < tab.size()) begin
        sel0   = !on3;
        sel3   = on3;
        htrans = 2'b10;
        haddr  = tab[i].addr;
        hwrite = tab[i].wr;
        hsize  = tab[i].size;
        sb_q.push_back('{tab[i].wr, tab[i].exp_rd, tab[i].err,
                         tab[i].err ? 2 : (on3 ? 4 : 1), vec_id});
        vec_id++;
      end else begin
        sel0   = 1'b0;
        sel3   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (have_prev && prev.wr) ? prev.wdata : 32'h0;
      finish_phase(have_prev);
      have_prev = (i < tab.size());
      if (have_prev) prev = tab[i];
      @(posedge clk);
      #1;
    end
    tab.delete();
  endtask

  task automatic fill_main();
    add(1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        0);
    add(0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 0);
    add(1, 32'h20,   3'd2, 32'hAABBCCDD, 32'h0,        0);
    add(1, 32'h21,   3'd0, 32'h00001100, 32'h0,        0);
    add(1, 32'h23,   3'd0, 32'h22000000, 32'h0,        0);
    add(0, 32'h20,   3'd2, 32'h0,        32'h22BB11DD, 0);
    add(1, 32'h12,   3'd1, 32'h55660000, 32'h0,        0);
    add(0, 32'h10,   3'd2, 32'h0,        32'h5566BEEF, 0);
    add(0, 32'h1000, 3'd2, 32'h0,        32'h0,        1);
    add(0, 32'h3,    3'd1, 32'h0,        32'h0,        1);
    add(1, 32'h8,    3'd3, 32'h01234567, 32'h0,        1);
    add(1, 32'h11,   3'd1, 32'hFFFFFFFF, 32'h0,        1);
    add(0, 32'h10,   3'd2, 32'h0,        32'h5566BEEF, 0);
    add(1, 32'hFFC,  3'd2, 32'h0F0F0F0F, 32'h0,        0);
    add(0, 32'hFFC,  3'd2, 32'h0,        32'h0F0F0F0F, 0);
    add(1, 32'h40,   3'd2, 32'h12345678, 32'h0,        0);
    add(0, 32'h40,   3'd2, 32'h0,        32'h12345678, 0);
  endtask

  initial begin
    hreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst ro0", 32'(ro0), 32'd1);
    check("rst rs0", 32'(rs0), 32'd0);
    check("rst rd0", rd0, 32'h0);
    check("rst ro3", 32'(ro3), 32'd1);
    check("rst rs3", 32'(rs3), 32'd0);
    check("rst rd3", rd3, 32'h0);
    hreset = 1'b0;
    @(posedge clk);
    #1;

    on3 = 1'b0;
    fill_main();
    run_tab();
    on3 = 1'b1;
    fill_main();
    run_tab();

    // Selected IDLE transfer: no data phase, nothing written.
    on3    = 1'b0;
    sel0   = 1'b1;
    htrans = 2'b00;
    hwrite = 1'b1;
    haddr  = 32'h10;
    hsize  = 3'd2;
    @(posedge clk);
    #1;
    sel0   = 1'b0;
    hwdata = 32'hFFFFFFFF;
    check("idle ro0", 32'(ro0), 32'd1);
    check("idle rs0", 32'(rs0), 32'd0);
    @(posedge clk);
    #1;
    add(0, 32'h10, 3'd2, 32'h0, 32'h5566BEEF, 0);
    run_tab();

    // NONSEQ while hready is low belongs to another slave's data phase.
    on3      = 1'b1;
    force_lo = 1'b1;
    sel3     = 1'b1;
    htrans   = 2'b10;
    hwrite   = 1'b1;
    haddr    = 32'h40;
    @(posedge clk);
    #1;
    force_lo = 1'b0;
    sel3     = 1'b0;
    htrans   = 2'b00;
    hwdata   = 32'hFFFFFFFF;
    check("hready_lo ro3", 32'(ro3), 32'd1);
    check("hready_lo rs3", 32'(rs3), 32'd0);
    @(posedge clk);
    #1;
    add(0, 32'h40, 3'd2, 32'h0, 32'h12345678, 0);
    run_tab();

    // Reset in the second wait cycle of a write aborts it.
    add(1, 32'h50, 3'd2, 32'hCAFEF00D, 32'h0, 0);
    run_tab();
    sel3   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = 32'h50;
    hsize  = 3'd2;
    @(posedge clk);
    #1;
    sel3   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h0BADF00D;
    check("abort wait1 ro3", 32'(ro3), 32'd0);
    @(posedge clk);
    #1;
    check("abort wait2 ro3", 32'(ro3), 32'd0);
    hreset = 1'b1;
    @(posedge clk);
    #1;
    check("abort ro3", 32'(ro3), 32'd1);
    check("abort rs3", 32'(rs3), 32'd0);
    check("abort rd3", rd3, 32'h0);
    hreset = 1'b0;
    hwdata = 32'h0;
    @(posedge clk);
    #1;
    add(0, 32'h50, 3'd2, 32'h0, 32'hCAFEF00D, 0);
    run_tab();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
